vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  VGA timing master and pixel sink for 640x480@60 (25 MHz clk). Generates hsync/vsync,
//  issues pixel coordinates (pix_x/pix_y) to the pixel-data generator one clock early,
//  and gates the returned RGB565 pix_data onto the display bus during the visible window.
//  Sits between the VGA_Data generators and the board RGB/sync pins.
// PARAMETERS
//  H_SYNC   96   hsync pulse width, clocks
//  H_BACK   48   horizontal back porch, clocks
//  H_VALID  640  visible pixels per line
//  H_FRONT  16   horizontal front porch; H_TOTAL = sum = 800
//  V_SYNC   2    vsync pulse width, lines
//  V_BACK   33   vertical back porch, lines
//  V_VALID  480  visible lines
//  V_FRONT  10   vertical front porch; V_TOTAL = sum = 525
// PORTS
//  clk         in   1   pixel clock, 25 MHz
//  rst_n       in   1   asynchronous reset, active-low
//  pix_data    in   16  RGB565 from the generator; registered there, valid 1 clk after pix_x/pix_y
//  pix_x       out  10  requested column 0..H_VALID-1; 10'h3FF when no request
//  pix_y       out  10  requested row 0..V_VALID-1; 10'h3FF when no request
//  hsync       out  1   horizontal sync, active-high pulse
//  vsync       out  1   vertical sync, active-high pulse
//  rgb         out  16  RGB565 to DAC; 16'h0000 outside the visible window
//  frame_start out  1   only with VGA_FRAME_PULSE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - cnt_h (10b): 0..H_TOTAL-1, +1 every clk, wraps to 0. cnt_v (10b): +1 when cnt_h wraps, 0..V_TOTAL-1, wraps to 0.
//  - Reset (async, any time incl. mid-frame): cnt_h=0, cnt_v=0. Outputs follow the decode below, so in reset:
//    hsync=1, vsync=1, pix_x=pix_y=10'h3FF, rgb=0. First edge after release: cnt_h=1.
//  - hsync = (cnt_h < H_SYNC); vsync = (cnt_v < V_SYNC); combinational from registered counters.
//  - HA = H_SYNC+H_BACK (144), VA = V_SYNC+V_BACK (35).
//  - rgb_valid = HA <= cnt_h < HA+H_VALID, and VA <= cnt_v < VA+V_VALID.
//  - pix_req = HA-1 <= cnt_h < HA+H_VALID-1, with the same cnt_v range; one clk ahead of rgb_valid.
//  - pix_x = pix_req ? cnt_h-(HA-1) : 10'h3FF; pix_y = pix_req ? cnt_v-VA : 10'h3FF.
//  - rgb = rgb_valid ? pix_data : 16'h0000. Total latency: coordinate issued at cycle N, pixel on rgb at N+1.
//  - The generator receives exactly H_VALID*V_VALID non-3FF coordinates per frame, in raster order.
//  - Subtractions are 10-bit unsigned and evaluated only inside the request window, so no underflow.
//  - Line wrap and frame wrap on the same edge (cnt_h=799, cnt_v=524): both counters go to 0.
//  - All parameters are fixed at elaboration. Any H_TOTAL or V_TOTAL > 1023 is illegal.
// CONFIGURATION
//  VGA_FRAME_PULSE_EN defined: adds output frame_start (1b), a registered 1-clk pulse in the clk
//    after cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1, i.e. coincident with cnt_h=cnt_v=0. Reset value 0.
//    No pulse while rst_n is low. The first pulse comes after the first full frame following release.
//  VGA_FRAME_PULSE_EN undefined: the port and its logic are absent. All other behaviour is identical.
// TESTING
//  1 Reset: hold rst_n=0 for 10 clk -> hsync=1, vsync=1, pix_x=pix_y=3FF, rgb=0 throughout.
//  2 Line timing: free-run -> hsync high for 96 clk, period 800 clk. vsync high for 1600 clk, period 420000 clk.
//  3 Alignment: line cnt_v=35 -> pix_x=0 at cnt_h=143 and pix_x=639 at cnt_h=782.
//    With a model where pix_data={pix_y[4:0],pix_x[5:0],pix_x[4:0]} registered, rgb at cnt_h=144 equals pixel(0,35-35).
//  4 Solid red: model returns 16'hF800 for non-3FF coordinates -> exactly 307200 rgb=F800 cycles per frame.
//    rgb=0 on the other 112800 cycles. pix_y=3FF on lines 0..34 and 515..524.
//  5 Mid-frame reset: assert rst_n=0 at cnt_v=200, cnt_h=400 for 3 clk -> outputs reach reset values
//    asynchronously. After release, the first hsync falls 96 clk later and the next vsync period is 420000 clk.
//  6 VGA_FRAME_PULSE_EN: compile with the macro -> frame_start is a single 1-clk pulse every 420000 clk,
//    aligned to hsync & vsync rising. Compile without -> port absent, tests 1-5 still pass.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA 640x480@60 timing master: hsync/vsync, pixel coordinates issued one clock early, RGB565 gating.
// Optional macro VGA_FRAME_PULSE_EN adds a registered frame_start pulse at cnt_h = cnt_v = 0.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_VALID = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_VALID = 480,
    parameter int unsigned V_FRONT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb
`ifdef VGA_FRAME_PULSE_EN
    ,
    output logic        frame_start
`endif
);

    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] H_ACT    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_REQ    = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_END    = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] H_REQEND = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] V_ACT    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       h_last, v_last;
    logic       v_win, rgb_valid, pix_req;

    assign h_last = (cnt_h_q == H_LAST);
    assign v_last = (cnt_v_q == V_LAST);

    always_comb begin
        cnt_h_d = h_last ? '0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (h_last) begin
            cnt_v_d = v_last ? '0 : cnt_v_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Request window leads the visible window by one clock to cover the generator's register stage.
    always_comb begin
        hsync     = (cnt_h_q < H_SYNC_C);
        vsync     = (cnt_v_q < V_SYNC_C);
        v_win     = (cnt_v_q >= V_ACT) && (cnt_v_q < V_END);
        rgb_valid = (cnt_h_q >= H_ACT) && (cnt_h_q < H_END) && v_win;
        pix_req   = (cnt_h_q >= H_REQ) && (cnt_h_q < H_REQEND) && v_win;
        pix_x     = '1;
        pix_y     = '1;
        if (pix_req) begin
            pix_x = cnt_h_q - H_REQ;
            pix_y = cnt_v_q - V_ACT;
        end
        rgb = rgb_valid ? pix_data : '0;
    end

`ifdef VGA_FRAME_PULSE_EN
    logic frame_start_q, frame_start_d;

    assign frame_start_d = h_last && v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed self-checking bench for vga_timing_ctrl: full-size instance plus a scaled-down instance for frame-level checks.
// Frame-pulse checks are compiled in only when VGA_FRAME_PULSE_EN is defined.
module tb_vga_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_s = 1'b0;
    logic [15:0] pd, pd_s;
    logic [9:0]  px, py, pxs, pys;
    logic        hs, vs, hss, vss;
    logic [15:0] rgb, rgbs;
`ifdef VGA_FRAME_PULSE_EN
    logic        fs, fss;
`endif

    int total = 0;
    int bad = 0;
    int kb = 0;
    int ks = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pix_data(pd), .pix_x(px), .pix_y(py),
        .hsync(hs), .vsync(vs), .rgb(rgb)
`ifdef VGA_FRAME_PULSE_EN
        , .frame_start(fs)
`endif
    );

    // Scaled timing: 17 clocks per line (active 7..14), 11 lines per frame (active 5..8), 187 clocks per frame.
    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VALID(4), .V_FRONT(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .pix_data(pd_s), .pix_x(pxs), .pix_y(pys),
        .hsync(hss), .vsync(vss), .rgb(rgbs)
`ifdef VGA_FRAME_PULSE_EN
        , .frame_start(fss)
`endif
    );

    // Pixel generators: register the data one clock after the coordinate.
    always @(posedge clk) begin
        pd   <= {py[4:0], px[5:0], px[4:0]};
        pd_s <= (pxs != 10'h3FF && pys != 10'h3FF) ? 16'hF800 : 16'h0000;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        kb++;
        ks++;
    endtask

    task automatic goto_b(input int t);
        while (kb < t) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (hs !== 1'b1 || vs !== 1'b1 || px !== 10'h3FF || py !== 10'h3FF || rgb !== 16'h0000) begin
                bad++;
                $display("FAIL reset cyc=%0d got hs=%b vs=%b x=%h y=%h rgb=%h exp hs=1 vs=1 x=3ff y=3ff rgb=0000",
                         i, hs, vs, px, py, rgb);
            end
`ifdef VGA_FRAME_PULSE_EN
            total++;
            if (fs !== 1'b0) begin
                bad++;
                $display("FAIL reset_fs got=%b exp=0", fs);
            end
`endif
        end
        rst_n = 1'b1;
        kb = 0;
    endtask

    task automatic test_line_timing();
        int hs_cnt = 0;
        int vs_cnt = 0;
        int pk[11]  = '{0, 95, 96, 799, 800, 895, 896, 1599, 1600, 1695, 1696};
        logic ph[11] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
        logic pv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int p = 0;
        while (kb < 2400) begin
            if (hs === 1'b1) hs_cnt++;
            if (vs === 1'b1) vs_cnt++;
            if (p < 11 && kb == pk[p]) begin
                total++;
                if (hs !== ph[p] || vs !== pv[p]) begin
                    bad++;
                    $display("FAIL sync_point k=%0d got hs=%b vs=%b exp hs=%b vs=%b", kb, hs, vs, ph[p], pv[p]);
                end
                p++;
            end
            tick();
        end
        total++;
        if (hs_cnt != 288) begin
            bad++;
            $display("FAIL hsync_width got=%0d exp=288", hs_cnt);
        end
        total++;
        if (vs_cnt != 1600) begin
            bad++;
            $display("FAIL vsync_width got=%0d exp=1600", vs_cnt);
        end
    endtask

    task automatic test_alignment();
        int req = 0;
        goto_b(34 * 800 + 300);
        total++;
        if (px !== 10'h3FF || py !== 10'h3FF) begin
            bad++;
            $display("FAIL blank_line34 got x=%h y=%h exp x=3ff y=3ff", px, py);
        end
        goto_b(35 * 800 + 142);
        total++;
        if (px !== 10'h3FF || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL pre_window got x=%h rgb=%h exp x=3ff rgb=0000", px, rgb);
        end
        tick();
        while (kb < 36 * 800) begin
            if (px !== 10'h3FF) req++;
            if (kb == 35 * 800 + 143) begin
                total++;
                if (px !== 10'd0 || py !== 10'd0 || rgb !== 16'h0000) begin
                    bad++;
                    $display("FAIL first_req got x=%h y=%h rgb=%h exp x=000 y=000 rgb=0000", px, py, rgb);
                end
            end
            if (kb == 35 * 800 + 145) begin
                total++;
                if (rgb !== 16'h0021) begin
                    bad++;
                    $display("FAIL pix1_rgb got=%h exp=0021", rgb);
                end
            end
            if (kb == 35 * 800 + 782) begin
                total++;
                if (px !== 10'd639) begin
                    bad++;
                    $display("FAIL last_req got=%0d exp=639", px);
                end
            end
            if (kb == 35 * 800 + 783) begin
                total++;
                if (px !== 10'h3FF || rgb !== 16'h07FF) begin
                    bad++;
                    $display("FAIL last_rgb got x=%h rgb=%h exp x=3ff rgb=07ff", px, rgb);
                end
            end
            if (kb == 35 * 800 + 784) begin
                total++;
                if (rgb !== 16'h0000) begin
                    bad++;
                    $display("FAIL post_window got=%h exp=0000", rgb);
                end
            end
            tick();
        end
        total++;
        if (req != 640) begin
            bad++;
            $display("FAIL req_per_line got=%0d exp=640", req);
        end
        goto_b(36 * 800 + 200);
        total++;
        if (px !== 10'd57 || py !== 10'd1 || rgb !== 16'h0F18) begin
            bad++;
            $display("FAIL line36 got x=%0d y=%0d rgb=%h exp x=57 y=1 rgb=0f18", px, py, rgb);
        end
    endtask

    task automatic test_mid_reset();
        goto_b(40 * 800 + 400);
        total++;
        if (px !== 10'd257 || py !== 10'd5 || hs !== 1'b0 || vs !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset got x=%0d y=%0d hs=%b vs=%b exp x=257 y=5 hs=0 vs=0", px, py, hs, vs);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (hs !== 1'b1 || vs !== 1'b1 || px !== 10'h3FF || py !== 10'h3FF || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset got hs=%b vs=%b x=%h y=%h rgb=%h exp hs=1 vs=1 x=3ff y=3ff rgb=0000",
                     hs, vs, px, py, rgb);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (hs !== 1'b1 || vs !== 1'b1 || px !== 10'h3FF || rgb !== 16'h0000) begin
            bad++;
            $display("FAIL held_reset got hs=%b vs=%b x=%h rgb=%h exp hs=1 vs=1 x=3ff rgb=0000", hs, vs, px, rgb);
        end
        rst_n = 1'b1;
        kb = 0;
        goto_b(95);
        total++;
        if (hs !== 1'b1) begin
            bad++;
            $display("FAIL rel_hs95 got=%b exp=1", hs);
        end
        tick();
        total++;
        if (hs !== 1'b0) begin
            bad++;
            $display("FAIL rel_hs96 got=%b exp=0", hs);
        end
        goto_b(1599);
        total++;
        if (vs !== 1'b1) begin
            bad++;
            $display("FAIL rel_vs1599 got=%b exp=1", vs);
        end
        tick();
        total++;
        if (vs !== 1'b0) begin
            bad++;
            $display("FAIL rel_vs1600 got=%b exp=0", vs);
        end
    endtask

    task automatic test_frame();
        int red = 0;
        int blk = 0;
        int vsc = 0;
        int ybad = 0;
        int ex = 0;
        int ey = 0;
        int line;
`ifdef VGA_FRAME_PULSE_EN
        int pulses = 0;
`endif
        rst_s = 1'b1;
        ks = 0;
        while (ks <= 374) begin
            line = (ks % 187) / 17;
            if (ks < 187) begin
                if (rgbs === 16'hF800) red++;
                if (rgbs === 16'h0000) blk++;
                if (vss === 1'b1) vsc++;
                if ((line < 5 || line > 8) && pys !== 10'h3FF) ybad++;
            end
            if (pxs !== 10'h3FF) begin
                total++;
                if (pxs !== 10'(ex) || pys !== 10'(ey)) begin
                    bad++;
                    $display("FAIL raster k=%0d got x=%0d y=%0d exp x=%0d y=%0d", ks, pxs, pys, ex, ey);
                end
                ex++;
                if (ex == 8) begin
                    ex = 0;
                    ey = (ey == 3) ? 0 : ey + 1;
                end
            end
            if (ks == 186) begin
                total++;
                if (hss !== 1'b0 || vss !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_end got hs=%b vs=%b exp hs=0 vs=0", hss, vss);
                end
            end
            if (ks == 187) begin
                total++;
                if (hss !== 1'b1 || vss !== 1'b1 || pxs !== 10'h3FF) begin
                    bad++;
                    $display("FAIL frame_wrap got hs=%b vs=%b x=%h exp hs=1 vs=1 x=3ff", hss, vss, pxs);
                end
            end
`ifdef VGA_FRAME_PULSE_EN
            if (fss === 1'b1) pulses++;
            if (ks == 186 || ks == 187 || ks == 188) begin
                total++;
                if (fss !== (ks == 187)) begin
                    bad++;
                    $display("FAIL frame_start k=%0d got=%b exp=%b", ks, fss, (ks == 187));
                end
            end
`endif
            tick();
        end
        total++;
        if (red != 32 || blk != 155) begin
            bad++;
            $display("FAIL solid_red got red=%0d blank=%0d exp red=32 blank=155", red, blk);
        end
        total++;
        if (vsc != 34) begin
            bad++;
            $display("FAIL small_vsync got=%0d exp=34", vsc);
        end
        total++;
        if (ybad != 0) begin
            bad++;
            $display("FAIL blank_lines got=%0d exp=0", ybad);
        end
`ifdef VGA_FRAME_PULSE_EN
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL frame_pulses got=%0d exp=2", pulses);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_alignment();
        test_mid_reset();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
